// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared widths, the zero-register constant and the grant type
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;
endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard : pending-write vector plus decode-stage busy lookup (opt. WB_FORWARD_EN)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
`ifdef WB_FORWARD_EN
  , parameter int DATA_W = DATA_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_a_i,
`ifdef WB_FORWARD_EN
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] fwd1_o,
  output logic [DATA_W-1:0] fwd2_o,
`endif
  input  logic [ADDR_W-1:0] chk_a1_i,
  input  logic [ADDR_W-1:0] chk_a2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              busy_any_o
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            nz1;
  logic            nz2;

  // Clear is applied first so a same-cycle set to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_a_i] = 1'b0;
    if (issue_en_i && (issue_addr_i != ADDR_W'(REG_ZERO))) busy_d[issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign nz1        = (chk_a1_i != ADDR_W'(REG_ZERO));
  assign nz2        = (chk_a2_i != ADDR_W'(REG_ZERO));
  assign busy_any_o = |busy_q;

`ifdef WB_FORWARD_EN
  logic hit1;
  logic hit2;
  assign hit1    = wr_en_i && nz1 && (wr_a_i == chk_a1_i);
  assign hit2    = wr_en_i && nz2 && (wr_a_i == chk_a2_i);
  assign busy1_o = nz1 && busy_q[chk_a1_i] && !hit1;
  assign busy2_o = nz2 && busy_q[chk_a2_i] && !hit2;
  assign fwd1_o  = hit1 ? wr_data_i : '0;
  assign fwd2_o  = hit2 ? wr_data_i : '0;
`else
  assign busy1_o = nz1 && busy_q[chk_a1_i];
  assign busy2_o = nz2 && busy_q[chk_a2_i];
`endif
endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : two-port writeback arbiter with anti-starvation and scoreboard
// Optional macro WB_FORWARD_EN adds fwd1/fwd2 bypass outputs.  Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] chk_a1,
  input  logic [ADDR_W-1:0] chk_a2,
  output logic              busy1,
  output logic              busy2,
`ifdef WB_FORWARD_EN
  output logic [DATA_W-1:0] fwd1,
  output logic [DATA_W-1:0] fwd2,
`endif
  output logic              write_en,
  output logic [ADDR_W-1:0] write_a,
  output logic [DATA_W-1:0] write_data,
  output logic              idle
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  grant_e            gnt;
  logic [SW-1:0]     starve_q, starve_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_a_q, write_a_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              busy_any;

  // B wins only when A is absent or B has lost STARVE_MAX cycles in a row.
  always_comb begin
    gnt = GNT_NONE;
    if (b_valid && (!a_valid || (starve_q == STARVE_LIM))) gnt = GNT_B;
    else if (a_valid)                                        gnt = GNT_A;
  end

  assign a_ready = rst_n && (gnt == GNT_A);
  assign b_ready = rst_n && (gnt == GNT_B);

  always_comb begin
    starve_d = starve_q;
    if (!b_valid || (gnt == GNT_B)) starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    write_a_d    = write_a_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    if (gnt == GNT_B) begin
      write_a_d    = b_addr;
      write_data_d = b_data;
    end else if (gnt == GNT_A) begin
      write_a_d    = a_addr;
      write_data_d = a_data;
    end
    if (gnt != GNT_NONE) write_en_d = (write_a_d != ADDR_W'(REG_ZERO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= '0;
      write_en_q   <= 1'b0;
      write_a_q    <= '0;
      write_data_q <= '0;
    end else begin
      starve_q     <= starve_d;
      write_en_q   <= write_en_d;
      write_a_q    <= write_a_d;
      write_data_q <= write_data_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_a    = write_a_q;
  assign write_data = write_data_q;
  assign idle       = !rst_n || (!busy_any && !a_valid && !b_valid && !write_en_q);

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
`ifdef WB_FORWARD_EN
    , .DATA_W (DATA_W)
`endif
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .wr_en_i      (write_en_q),
    .wr_a_i       (write_a_q),
`ifdef WB_FORWARD_EN
    .wr_data_i    (write_data_q),
    .fwd1_o       (fwd1),
    .fwd2_o       (fwd2),
`endif
    .chk_a1_i     (chk_a1),
    .chk_a2_i     (chk_a2),
    .busy1_o      (busy1),
    .busy2_o      (busy2),
    .busy_any_o   (busy_any)
  );
endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width (32 registers).
REQ-002 SHALL have parameter DATA_W, default 32, writeback data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive lost cycles after which requester B is forced a grant.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have the following ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid / a_ready  in / out  1 / 1  ALU writeback handshake.
- a_addr / a_data  in  ADDR_W / DATA_W  ALU destination and value.
- b_valid / b_ready  in / out  1 / 1  long-latency unit (load/mul-div) writeback handshake.
- b_addr / b_data  in  ADDR_W / DATA_W  long-latency destination and value.
- issue_en / issue_addr  in  1 / ADDR_W  mark a destination pending at instruction issue.
- chk_a1 / chk_a2  in  ADDR_W  decode-stage source addresses.
- busy1 / busy2  out  1  source has a pending write.
- write_en / write_a / write_data  out  1 / ADDR_W / DATA_W  registered register-file write port.
- idle  out  1  no pending writes, no valid request, write_en low.

Function
REQ-006 SHALL accept a transfer on a port when valid and ready are both high on a posedge; ready SHALL depend only on valids and state, never on ready.
REQ-007 SHALL grant at most one requester per cycle; A wins by default.
REQ-008 SHALL grant B when b_valid and not a_valid, or when b_valid and starve_cnt == STARVE_MAX.
REQ-009 SHALL increment starve_cnt each cycle b_valid is high and B is not granted, saturating at STARVE_MAX, and SHALL clear it when B is accepted or b_valid is low.
REQ-010 SHALL register the accepted transfer: write_en, write_a and write_data SHALL be valid the cycle after acceptance, giving 1-cycle latency; the register file captures on the following negedge.
REQ-011 SHALL accept transfers to address 0 normally but SHALL hold write_en low for them.
REQ-012 SHALL keep a 32-bit busy vector: issue_en sets busy[issue_addr]; the cycle write_en is high clears busy[write_a]; issue_addr 0 SHALL be ignored.
REQ-013 SHALL let the set win when a set and a clear hit the same address in one cycle.
REQ-014 SHALL drive busyN = busy[chk_aN]; busyN SHALL be 0 when chk_aN == 0.
REQ-015 SHALL not check whether a write's address is busy; a write to a non-busy register SHALL still occur and leave busy at 0.

Reset
REQ-016 SHALL, on rst_n low, immediately clear busy, starve_cnt, write_en, write_a and write_data to 0; a_ready and b_ready SHALL be 0 while in reset, and idle SHALL be 1.
REQ-017 SHALL discard any transfer accepted in the cycle reset asserts; no write SHALL issue after reset deasserts without a new acceptance.

Configuration
REQ-018 SHALL support macro WB_FORWARD_EN.
REQ-019 SHALL, with WB_FORWARD_EN defined:
- add outputs fwd1 and fwd2, DATA_W each;
- when write_en is high and write_a == chk_aN (nonzero), force busyN to 0 and set fwdN = write_data;
- otherwise drive fwdN to 0.
REQ-020 SHALL, without WB_FORWARD_EN, omit fwd1/fwd2, and busyN SHALL stay high through the write_en cycle.

Structure
REQ-021 SHALL take ADDR_W/DATA_W defaults and constant REG_ZERO in shared package regfile_pkg.
REQ-022 SHALL implement the busy vector and the busyN/fwdN lookup in sub-module rf_scoreboard; arbitration and the output register stay in the top.

Verification
REQ-023 SHALL cover both valid at once, a_addr 3 = 0x11, b_addr 4 = 0x22 -> A first; write_en is high next cycle with write_a 3, write_data 0x11; B is then accepted.
REQ-024 SHALL cover a_valid held high and b_valid held high for 10 cycles, STARVE_MAX 4 -> B is accepted on the 5th cycle and starve_cnt is 0 after it.
REQ-025 SHALL cover issue 7, then a B write to 7 -> busy1 is 1 for chk_a1 7 until write_en clears it, and 0 for chk_a1 0 always.
REQ-026 SHALL cover issue_en 9 in the same cycle as write_en to 9 -> busy[9] stays 1.
REQ-027 SHALL cover an A write to address 0 with data 0xFF -> a_ready is 1 and write_en stays 0.
REQ-028 SHALL cover rst_n low mid-transfer with busy 0x80 -> busy 0, write_en 0 and idle 1 immediately; with WB_FORWARD_EN, write 5 = 0xAB with chk_a2 5 -> busy2 0 and fwd2 0xAB that cycle.
